// File: rtl/tt_pkg.sv
// ============================================================================
//  Module   : tt_pkg
//  Purpose  : Shared types, sizing helpers and golden tables for the
//             truth-table sweeper and its lab harness.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_pkg;

  // Sweeper FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  // Golden truth table of the lab function unit, bit i = z for vector i
  localparam logic [31:0] TT_PRATICA_I = 32'hFF141414;

  // Size of the vector space for an n-input function
  function automatic int tt_depth(input int n);
    return 1 << n;
  endfunction

  // Settle counter width; it must be able to hold the value SETTLE
  function automatic int tt_cnt_w(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tt_func_unit.sv
// ============================================================================
//  Module   : tt_func_unit
//  Purpose  : Five-input lab function unit; z is 1 when a and b are both
//             high, or when exactly one of c/d is high and e is low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_func_unit (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  output logic z
);

  assign z = (a & b) | ((c ^ d) & ~e);

endmodule

`default_nettype wire

// File: rtl/tt_sweep_top.sv
// ============================================================================
//  Module   : tt_sweep_top
//  Purpose  : Lab harness pairing the sweeper with the 5-input function
//             unit; vec drives {a,b,c,d,e} with a as the MSB.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_sweep_top
  import tt_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] expected,
  output logic [4:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_out,
  output logic [5:0]  ones,
  output logic        mismatch,
  output logic [4:0]  first_err,
  output logic [5:0]  err_count
);

  logic w_z;

  truth_table_sweeper #(
    .N_IN   (5),
    .SETTLE (SETTLE)
  ) u_sweep (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .expected  (expected),
    .z         (w_z),
    .vec       (vec),
    .busy      (busy),
    .done      (done),
    .table_out (table_out),
    .ones      (ones),
    .mismatch  (mismatch),
    .first_err (first_err),
    .err_count (err_count)
  );

  tt_func_unit u_fu (
    .a (vec[4]),
    .b (vec[3]),
    .c (vec[2]),
    .d (vec[1]),
    .e (vec[0]),
    .z (w_z)
  );

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
//  Module   : truth_table_sweeper
//  Purpose  : Steps a combinational N_IN-input function unit through every
//             input vector, samples z after a settle interval, builds the
//             truth table and checks it against a latched golden table.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN   = 5,
  parameter int SETTLE = 2,    // must be >= 1
  localparam int DEPTH = tt_depth(N_IN),
  localparam int CNT_W = tt_cnt_w(SETTLE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DEPTH-1:0] expected,
  input  logic             z,
  output logic [N_IN-1:0]  vec,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] table_out,
  output logic [N_IN:0]    ones,
  output logic             mismatch,
  output logic [N_IN-1:0]  first_err,
  output logic [N_IN:0]    err_count
);

  localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN-1:0]  IDX_ONE  = N_IN'(1);
  localparam logic [N_IN:0]    STAT_MAX = (N_IN + 1)'(DEPTH);
  localparam logic [N_IN:0]    STAT_ONE = (N_IN + 1)'(1);

  tt_state_e        state_q;
  logic [DEPTH-1:0] exp_q;
  logic [DEPTH-1:0] table_q;
  logic [N_IN-1:0]  idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_IN:0]    ones_q;
  logic [N_IN:0]    err_count_q;
  logic             mismatch_q;
  logic [N_IN-1:0]  first_err_q;
  logic             busy_q;
  logic             done_q;

  logic             z_bad;
  logic [N_IN:0]    ones_d;
  logic [N_IN:0]    err_count_d;
  logic             mismatch_d;
  logic [N_IN-1:0]  first_err_d;

  // Statistics update for the vector currently being sampled; the counters
  // saturate at DEPTH so a full sweep can never wrap them.
  always_comb begin
    z_bad       = z ^ exp_q[idx_q];
    ones_d      = ones_q;
    err_count_d = err_count_q;
    mismatch_d  = mismatch_q;
    first_err_d = first_err_q;
    if (z && (ones_q != STAT_MAX)) begin
      ones_d = ones_q + STAT_ONE;
    end
    if (z_bad) begin
      if (err_count_q != STAT_MAX) begin
        err_count_d = err_count_q + STAT_ONE;
      end
      if (!mismatch_q) begin
        mismatch_d  = 1'b1;
        first_err_d = idx_q;
      end
    end
  end

  // Sweep sequencer: IDLE -> (DRIVE^SETTLE -> SAMPLE)^DEPTH -> DONE -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      table_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ones_q      <= '0;
      err_count_q <= '0;
      mismatch_q  <= 1'b0;
      first_err_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_q       <= expected;
            table_q     <= '0;
            ones_q      <= '0;
            err_count_q <= '0;
            mismatch_q  <= 1'b0;
            first_err_q <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= DRIVE;
          end
        end
        DRIVE: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          table_q[idx_q] <= z;
          ones_q         <= ones_d;
          err_count_q    <= err_count_d;
          mismatch_q     <= mismatch_d;
          first_err_q    <= first_err_d;
          // Last-vector test comes first so idx never wraps past DEPTH-1
          if (idx_q == IDX_LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + IDX_ONE;
            cnt_q   <= '0;
            state_q <= DRIVE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vec       = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign ones      = ones_q;
  assign mismatch  = mismatch_q;
  assign first_err = first_err_q;
  assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
//  Module   : tb_truth_table_sweeper
//  Purpose  : Directed self-checking bench for the truth-table sweeper,
//             standalone (default and small configurations) and inside
//             the lab harness with the real function unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Harness instance with the real function unit
  logic        t_start = 1'b0;
  logic [31:0] t_exp = '0;
  logic [4:0]  t_vec, t_ferr;
  logic        t_busy, t_done, t_mis;
  logic [31:0] t_table;
  logic [5:0]  t_ones, t_errc;

  tt_sweep_top u_top (
    .clk(clk), .rst_n(rst_n), .start(t_start), .expected(t_exp),
    .vec(t_vec), .busy(t_busy), .done(t_done), .table_out(t_table),
    .ones(t_ones), .mismatch(t_mis), .first_err(t_ferr), .err_count(t_errc)
  );

  // Default sweeper with a bench-controlled function table or stuck-at-1 stub
  logic        d_start = 1'b0;
  logic [31:0] d_exp = '0;
  logic [31:0] d_tbl = '0;
  logic        d_stub = 1'b0;
  logic        d_z;
  logic [4:0]  d_vec, d_ferr;
  logic        d_busy, d_done, d_mis;
  logic [31:0] d_table;
  logic [5:0]  d_ones, d_errc;

  assign d_z = d_stub ? 1'b1 : d_tbl[d_vec];

  truth_table_sweeper u_dut (
    .clk(clk), .rst_n(rst_n), .start(d_start), .expected(d_exp), .z(d_z),
    .vec(d_vec), .busy(d_busy), .done(d_done), .table_out(d_table),
    .ones(d_ones), .mismatch(d_mis), .first_err(d_ferr), .err_count(d_errc)
  );

  // Small configuration: 3 inputs, 1 settle cycle, z = vec[0]
  logic        s_start = 1'b0;
  logic [7:0]  s_exp = '0;
  logic        s_z;
  logic [2:0]  s_vec, s_ferr;
  logic        s_busy, s_done, s_mis;
  logic [7:0]  s_table;
  logic [3:0]  s_ones, s_errc;

  assign s_z = s_vec[0];

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .expected(s_exp), .z(s_z),
    .vec(s_vec), .busy(s_busy), .done(s_done), .table_out(s_table),
    .ones(s_ones), .mismatch(s_mis), .first_err(s_ferr), .err_count(s_errc)
  );

  function automatic logic sel_done(input int which);
    case (which)
      0:       return t_done;
      1:       return d_done;
      default: return s_done;
    endcase
  endfunction

  // One-cycle start pulse; returns in the cycle after the accepting edge
  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) t_start = 1'b1; else if (which == 1) d_start = 1'b1; else s_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0; d_start = 1'b0; s_start = 1'b0;
  endtask

  // n = number of edges after the accepting edge when done is first seen
  task automatic wait_done(input int which, output int n);
    n = 0;
    while (!sel_done(which) && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (t_vec !== 5'd0 || t_busy !== 1'b0 || t_done !== 1'b0) begin n_err++; $display("FAIL reset_top_ctl got vec=%0d busy=%b done=%b want 0/0/0", t_vec, t_busy, t_done); end
    n_cmp++; if (t_table !== 32'h0 || t_ones !== 6'd0 || t_errc !== 6'd0) begin n_err++; $display("FAIL reset_top_stats got table=%h ones=%0d errc=%0d want 0", t_table, t_ones, t_errc); end
    n_cmp++; if (t_mis !== 1'b0 || t_ferr !== 5'd0) begin n_err++; $display("FAIL reset_top_err got mis=%b ferr=%0d want 0", t_mis, t_ferr); end
    n_cmp++; if (d_vec !== 5'd0 || d_busy !== 1'b0 || d_done !== 1'b0 || d_table !== 32'h0) begin n_err++; $display("FAIL reset_dut got vec=%0d busy=%b done=%b table=%h want 0", d_vec, d_busy, d_done, d_table); end
    n_cmp++; if (s_vec !== 3'd0 || s_busy !== 1'b0 || s_ones !== 4'd0 || s_table !== 8'h0) begin n_err++; $display("FAIL reset_small got vec=%0d busy=%b ones=%0d table=%h want 0", s_vec, s_busy, s_ones, s_table); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_golden();
    int n;
    t_exp = 32'hFF141414;
    pulse_start(0);
    n_cmp++; if (t_busy !== 1'b1) begin n_err++; $display("FAIL golden_busy got=%b want=1", t_busy); end
    wait_done(0, n);
    n_cmp++; if (n != 96) begin n_err++; $display("FAIL golden_done_edge got=%0d want=96", n); end
    n_cmp++; if (t_table !== 32'hFF141414) begin n_err++; $display("FAIL golden_table got=%h want=ff141414", t_table); end
    n_cmp++; if (t_ones !== 6'd14) begin n_err++; $display("FAIL golden_ones got=%0d want=14", t_ones); end
    n_cmp++; if (t_mis !== 1'b0 || t_errc !== 6'd0) begin n_err++; $display("FAIL golden_err got mis=%b errc=%0d want 0/0", t_mis, t_errc); end
    @(negedge clk);
    n_cmp++; if (t_done !== 1'b0 || t_busy !== 1'b0) begin n_err++; $display("FAIL golden_after got done=%b busy=%b want 0/0", t_done, t_busy); end
  endtask

  task automatic test_mismatch();
    int n;
    t_exp = 32'hFF141415;
    pulse_start(0);
    wait_done(0, n);
    n_cmp++; if (t_mis !== 1'b1) begin n_err++; $display("FAIL mism_flag got=%b want=1", t_mis); end
    n_cmp++; if (t_ferr !== 5'd0) begin n_err++; $display("FAIL mism_first got=%0d want=0", t_ferr); end
    n_cmp++; if (t_errc !== 6'd1) begin n_err++; $display("FAIL mism_count got=%0d want=1", t_errc); end
    n_cmp++; if (t_table !== 32'hFF141414) begin n_err++; $display("FAIL mism_table got=%h want=ff141414", t_table); end
    @(negedge clk);
  endtask

  task automatic test_stub_ones();
    int n;
    d_stub = 1'b1;
    d_exp  = 32'h0;
    pulse_start(1);
    wait_done(1, n);
    n_cmp++; if (n != 96) begin n_err++; $display("FAIL stub_done_edge got=%0d want=96", n); end
    n_cmp++; if (d_ones !== 6'd32) begin n_err++; $display("FAIL stub_ones got=%0d want=32", d_ones); end
    n_cmp++; if (d_errc !== 6'd32) begin n_err++; $display("FAIL stub_errc got=%0d want=32", d_errc); end
    n_cmp++; if (d_ferr !== 5'd0 || d_mis !== 1'b1) begin n_err++; $display("FAIL stub_first got ferr=%0d mis=%b want 0/1", d_ferr, d_mis); end
    n_cmp++; if (d_table !== 32'hFFFFFFFF) begin n_err++; $display("FAIL stub_table got=%h want=ffffffff", d_table); end
    d_stub = 1'b0;
    @(negedge clk);
  endtask

  // Mismatches at vectors 22 and 31 only; expected is changed after start
  task automatic test_first_err_latched();
    int n;
    d_tbl = 32'h0;
    d_exp = 32'h80400000;
    pulse_start(1);
    d_exp = 32'hFFFFFFFF;
    wait_done(1, n);
    n_cmp++; if (d_ferr !== 5'd22) begin n_err++; $display("FAIL ferr_first got=%0d want=22", d_ferr); end
    n_cmp++; if (d_errc !== 6'd2) begin n_err++; $display("FAIL ferr_count got=%0d want=2", d_errc); end
    n_cmp++; if (d_ones !== 6'd0 || d_table !== 32'h0) begin n_err++; $display("FAIL ferr_table got ones=%0d table=%h want 0/0", d_ones, d_table); end
    @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    int n;
    int dones;
    t_exp = 32'hFF141414;
    pulse_start(0);
    n = 0;
    while (!t_done && n < 400) begin
      t_start = (n == 4 || n == 49);
      @(negedge clk);
      n++;
    end
    t_start = 1'b0;
    n_cmp++; if (n != 96) begin n_err++; $display("FAIL restart_done_edge got=%0d want=96", n); end
    dones = 0;
    if (t_done) dones++;
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    repeat (20) begin
      if (t_done) dones++;
      @(negedge clk);
    end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL restart_pulses got=%0d want=1", dones); end
    n_cmp++; if (t_busy !== 1'b0) begin n_err++; $display("FAIL restart_idle got busy=%b want=0", t_busy); end
    n_cmp++; if (t_table !== 32'hFF141414 || t_ones !== 6'd14) begin n_err++; $display("FAIL restart_hold got table=%h ones=%0d want ff141414/14", t_table, t_ones); end
  endtask

  // Held start: second sweep is accepted at edge 98, the first IDLE edge
  task automatic test_held_start();
    int n;
    @(negedge clk);
    t_start = 1'b1;
    @(negedge clk);
    wait_done(0, n);
    n_cmp++; if (n != 96) begin n_err++; $display("FAIL held_done_edge got=%0d want=96", n); end
    @(negedge clk);
    n_cmp++; if (t_busy !== 1'b0 || t_done !== 1'b0) begin n_err++; $display("FAIL held_idle got busy=%b done=%b want 0/0", t_busy, t_done); end
    @(negedge clk);
    t_start = 1'b0;
    n_cmp++; if (t_busy !== 1'b1) begin n_err++; $display("FAIL held_retrig got busy=%b want=1", t_busy); end
    wait_done(0, n);
    n_cmp++; if (n != 96) begin n_err++; $display("FAIL held_second_edge got=%0d want=96", n); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int  n;
    logic seen;
    t_exp = 32'hFF141414;
    pulse_start(0);
    n = 0;
    while (t_vec != 5'd10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (t_vec !== 5'd10 || t_ones !== 6'd2) begin n_err++; $display("FAIL rmid_reach got vec=%0d ones=%0d want 10/2", t_vec, t_ones); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (t_vec !== 5'd0 || t_busy !== 1'b0 || t_done !== 1'b0) begin n_err++; $display("FAIL rmid_ctl got vec=%0d busy=%b done=%b want 0/0/0", t_vec, t_busy, t_done); end
    n_cmp++; if (t_table !== 32'h0 || t_ones !== 6'd0 || t_errc !== 6'd0 || t_mis !== 1'b0) begin n_err++; $display("FAIL rmid_stats got table=%h ones=%0d errc=%0d mis=%b want 0", t_table, t_ones, t_errc, t_mis); end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | t_done;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen = seen | t_done | t_busy;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rmid_nodone got activity=%b want=0", seen); end
    pulse_start(0);
    wait_done(0, n);
    n_cmp++; if (n != 96) begin n_err++; $display("FAIL rmid_rerun_edge got=%0d want=96", n); end
    n_cmp++; if (t_table !== 32'hFF141414 || t_ones !== 6'd14 || t_mis !== 1'b0) begin n_err++; $display("FAIL rmid_rerun got table=%h ones=%0d mis=%b want ff141414/14/0", t_table, t_ones, t_mis); end
    @(negedge clk);
  endtask

  task automatic test_small();
    int n;
    s_exp = 8'hAA;
    pulse_start(2);
    wait_done(2, n);
    n_cmp++; if (n != 16) begin n_err++; $display("FAIL small_done_edge got=%0d want=16", n); end
    n_cmp++; if (s_table !== 8'hAA) begin n_err++; $display("FAIL small_table got=%h want=aa", s_table); end
    n_cmp++; if (s_ones !== 4'd4) begin n_err++; $display("FAIL small_ones got=%0d want=4", s_ones); end
    n_cmp++; if (s_mis !== 1'b0 || s_errc !== 4'd0) begin n_err++; $display("FAIL small_err got mis=%b errc=%0d want 0/0", s_mis, s_errc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_mismatch();
    test_stub_ones();
    test_first_err_latched();
    test_restart_ignored();
    test_held_start();
    test_reset_mid();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
